// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-4 steering demultiplexer with valid/ready handshakes.
// Each output lane is a one-entry buffer, so a stalled consumer only blocks
// traffic addressed to its own lane.
// Optional macro DEMUX_CNT_EN adds saturating per-lane delivery counters cnt0..cnt3.
module demux_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  typedef enum logic {EMPTY, FULL} lane_state_t;

  lane_state_t      state [4];
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             acc;

  assign out0_data = data_q[0];
  assign out1_data = data_q[1];
  assign out2_data = data_q[2];
  assign out3_data = data_q[3];

  // A lane is ready when empty or being drained this cycle (pass-through refill).
  assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  // Decode lane occupancy and steer the accepted payload to its lane.
  always_comb begin
    out_valid = '0;
    load      = '0;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (state[i] == FULL);
    end
    if (acc) begin
      load[in_sel] = 1'b1;
    end
  end

  // Per-lane EMPTY/FULL state machine and payload register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state[i]  <= EMPTY;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data;
        end
        case (state[i])
          EMPTY: begin
            if (load[i]) begin
              state[i] <= FULL;
            end
          end
          FULL: begin
            if (drain[i] && !load[i]) begin
              state[i] <= EMPTY;
            end
          end
          default: state[i] <= EMPTY;
        endcase
      end
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

  // Count deliveries per lane, saturating at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: self-checking bench for demux_reg.
// A lane-occupancy model with per-lane scoreboard queues is compared against
// the DUT every cycle; directed steps add hand-computed literal expectations.
module tb_demux_reg;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic [1:0]       in_sel    = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data, out2_data, out3_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [WIDTH-1:0] dut_out [4];
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
  logic [CNT_W-1:0] dut_cnt [4];
  assign dut_cnt[0] = cnt0;
  assign dut_cnt[1] = cnt1;
  assign dut_cnt[2] = cnt2;
  assign dut_cnt[3] = cnt3;
`endif

  assign dut_out[0] = out0_data;
  assign dut_out[1] = out1_data;
  assign dut_out[2] = out2_data;
  assign dut_out[3] = out3_data;

  demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0_data(out0_data),
    .out1_data(out1_data),
    .out2_data(out2_data),
    .out3_data(out3_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1),
    .cnt2(cnt2),
    .cnt3(cnt3)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: which lanes hold a payload, what each lane shows, and what is owed.
  logic             m_valid [4];
  logic [WIDTH-1:0] m_data  [4];
  int               m_cnt   [4];
  logic [WIDTH-1:0] sb      [4][$];
  bit               model_live = 1'b0;
  logic             m_rdy;
  int               dut_xfer [4] = '{0, 0, 0, 0};

  // Producer-rule tracking.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [1:0]       prev_sel;
  logic             exp_rdy;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] s,
                               input logic [WIDTH-1:0] d, input logic [3:0] rdy);
    @(posedge clk);
    #1;
    rst_n     = rst;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
  endtask

  // Model update: drains free lanes, an accept fills the selected lane.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_live = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
        m_cnt[i]   = 0;
        sb[i].delete();
      end
    end else if (model_live) begin
      m_rdy = !m_valid[in_sel] || out_ready[in_sel];
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] && out_ready[i]) begin
          m_valid[i] = 1'b0;
          if (sb[i].size() > 0) void'(sb[i].pop_front());
          if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
        end
      end
      if (in_valid && m_rdy) begin
        m_valid[in_sel] = 1'b1;
        m_data[in_sel]  = in_data;
        sb[in_sel].push_back(in_data);
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (model_live) begin
      exp_rdy = rst_n && (!m_valid[in_sel] || out_ready[in_sel]);
      checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_valid[i]));
        checkOutput($sformatf("out%0d_data", i), 64'(dut_out[i]), 64'(m_data[i]));
`ifdef DEMUX_CNT_EN
        checkOutput($sformatf("cnt%0d", i), 64'(dut_cnt[i]), 64'(m_cnt[i]));
`endif
        if (rst_n && out_valid[i] && out_ready[i]) begin
          dut_xfer[i]++;
          if (sb[i].size() == 0) begin
            checkOutput($sformatf("spurious_delivery_lane%0d", i), 64'(1), 64'(0));
          end else begin
            checkOutput($sformatf("delivered_lane%0d", i), 64'(dut_out[i]), 64'(sb[i][0]));
          end
        end
      end
      if (rst_n && prev_stall) begin
        checkOutput("producer_hold", {31'd0, in_valid, prev_sel == in_sel, prev_data},
                    {31'd0, 1'b1, 1'b1, in_data});
      end
      prev_stall = rst_n && in_valid && !exp_rdy;
      prev_data  = in_data;
      prev_sel   = in_sel;
    end
  end

  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic             r_valid;
  logic             stall;
  int               x0;
  int               owed;

  initial begin
    // Reset held two cycles with a payload offered.
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h5, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h5, 4'b0000);
    checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'h0);
    checkOutput("rst_out2_data", 64'(out2_data), 64'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("release_in_ready", 64'(in_ready), 64'h1);

    // Basic steer to lane 2.
    applyStimulus(1'b1, 1'b1, 2'd2, 32'hDEADBEEF, 4'b1111);
    checkOutput("steer_in_ready", 64'(in_ready), 64'h1);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
    checkOutput("steer_out_valid", 64'(out_valid), 64'h4);
    checkOutput("steer_out2_data", 64'(out2_data), 64'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
    checkOutput("steer_drained", 64'(out_valid), 64'h0);
    checkOutput("steer_stale_data", 64'(out2_data), 64'hDEADBEEF);

    // Backpressure: lane1 blocks while lane3 still accepts.
    applyStimulus(1'b1, 1'b1, 2'd1, 32'hAAAA0001, 4'b0000);
    applyStimulus(1'b1, 1'b1, 2'd3, 32'hCCCC0003, 4'b0000);
    checkOutput("bp_lane3_ready", 64'(in_ready), 64'h1);
    applyStimulus(1'b1, 1'b1, 2'd1, 32'hBBBB0002, 4'b0000);
    checkOutput("bp_lane1_blocked", 64'(in_ready), 64'h0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'hA);
    applyStimulus(1'b1, 1'b1, 2'd1, 32'hBBBB0002, 4'b0010);
    checkOutput("bp_refill_ready", 64'(in_ready), 64'h1);
    checkOutput("bp_out1_a", 64'(out1_data), 64'hAAAA0001);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("bp_out1_b", 64'(out1_data), 64'hBBBB0002);
    checkOutput("bp_valid_kept", 64'(out_valid), 64'hA);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
    checkOutput("bp_all_drained", 64'(out_valid), 64'h0);

    // Simultaneous drain and load on lane0, no bubble.
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h7, 4'b0000);
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h1, 4'b0001);
    checkOutput("dl_in_ready", 64'(in_ready), 64'h1);
    checkOutput("dl_old_data", 64'(out0_data), 64'h7);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("dl_new_data", 64'(out0_data), 64'h1);
    checkOutput("dl_valid", 64'(out_valid), 64'h1);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0001);

    // Stream 100 words into lane0: 100 transfers in 101 cycles.
    x0 = dut_xfer[0];
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 32'(32'h1000 + k), 4'b0001);
    end
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0001);
    checkOutput("stream_transfers", 64'(dut_xfer[0] - x0), 64'd100);

    // Random traffic obeying the producer hold rule.
    r_valid = 1'b0; r_sel = '0; r_data = '0; stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!stall) begin
        r_valid = ($urandom_range(0, 1) == 1);
        r_sel   = 2'($urandom_range(0, 3));
        r_data  = $urandom;
      end
      applyStimulus(1'b1, r_valid, r_sel, r_data, 4'($urandom_range(0, 15)));
      stall = in_valid && m_valid[in_sel] && !out_ready[in_sel];
    end
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b1111);
    owed = 0;
    for (int i = 0; i < 4; i++) owed += sb[i].size();
    checkOutput("stress_nothing_owed", 64'(owed), 64'h0);
    checkOutput("stress_out_valid", 64'(out_valid), 64'h0);

    // Reset mid-operation discards buffered payloads.
    applyStimulus(1'b1, 1'b1, 2'd3, 32'h33, 4'b0000);
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h11, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h22, 4'b0000);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'h0);
    checkOutput("midrst_pre_valid", 64'(out_valid), 64'hA);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("midrst_out3_data", 64'(out3_data), 64'h0);

`ifdef DEMUX_CNT_EN
    // Counters: 3 drains on lane1, 20 on lane2 (saturates at 15), then reset.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 2'd1, 32'(k), 4'b0010);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b1, 2'd2, 32'(k), 4'b0110);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0100);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("cnt2_saturated", 64'(cnt2), 64'd15);
    checkOutput("cnt1_count", 64'(cnt1), 64'd3);
    checkOutput("cnt0_count", 64'(cnt0), 64'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkOutput("cnt_reset", {cnt0, cnt1, cnt2, cnt3}, 64'h0);
`endif

    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
